// File: rtl/pop_counter.sv
// Per-channel delivered-word counters for output FIFOs 4..7, with a
// req/idx readback port and an idle/active status FSM.
module pop_counter #(
  parameter int CNT_W = 5,
  parameter int NCH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             pop4,
  input  logic             pop5,
  input  logic             pop6,
  input  logic             pop7,
  input  logic             empty4,
  input  logic             empty5,
  input  logic             empty6,
  input  logic             empty7,
  input  logic             req,
  input  logic [1:0]       idx,
  output logic [CNT_W-1:0] counter_out,
  output logic             counter_valid,
  output logic             idle_out,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic             idle_reg;
  logic [CNT_W-1:0] out_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg [NCH];
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   empty;
  logic             run;

  assign pop   = {pop7, pop6, pop5, pop4};
  assign empty = {empty7, empty6, empty5, empty4};

  // Counting and reads happen only in IDLE/ACTIVE with init low; an init
  // sampled high in those states clears everything at that same edge.
  assign run = ((state_reg == ST_IDLE) || (state_reg == ST_ACTIVE)) && !init;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT:   if (!init) state_next = ST_IDLE;
      ST_IDLE: begin
        if (init)        state_next = ST_INIT;
        else if (!(&empty)) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)        state_next = ST_INIT;
        else if (&empty) state_next = ST_IDLE;
      end
      default:   state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_RESET;
      idle_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idle_reg  <= (state_next == ST_IDLE);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!reset || !run) begin
        count_reg[gi] <= '0;
      end else if (pop[gi] && !empty[gi]) begin
        count_reg[gi] <= count_reg[gi] + 1'b1;
      end
    end
  end

  // Read captures the pre-increment value since count_reg updates at the same edge.
  always_ff @(posedge clk) begin
    if (!reset || !run || !req) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      out_reg   <= count_reg[idx];
      valid_reg <= 1'b1;
    end
  end

  assign counter_out   = out_reg;
  assign counter_valid = valid_reg;
  assign idle_out      = idle_reg;
  assign state_out     = state_reg;

endmodule

// File: tb/tb_pop_counter.sv
// Directed bench for pop_counter: FSM sequencing, per-channel counting,
// empty-pop rejection, wrap, same-edge read/pop, init clear and mid-run reset.
module tb_pop_counter;

  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic             init;
  logic             pop4, pop5, pop6, pop7;
  logic             empty4, empty5, empty6, empty7;
  logic             req;
  logic [1:0]       idx;
  logic [CNT_W-1:0] counter_out;
  logic             counter_valid;
  logic             idle_out;
  logic [1:0]       state_out;

  int passed = 0;
  int total  = 0;

  pop_counter #(.CNT_W(CNT_W), .NCH(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
    .empty4(empty4), .empty5(empty5), .empty6(empty6), .empty7(empty7),
    .req(req), .idx(idx),
    .counter_out(counter_out), .counter_valid(counter_valid),
    .idle_out(idle_out), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pops(input logic [3:0] p);
    {pop7, pop6, pop5, pop4} = p;
  endtask

  task automatic set_empty(input logic [3:0] e);
    {empty7, empty6, empty5, empty4} = e;
  endtask

  // Single-cycle read: drive req for one edge, return what was captured.
  task automatic do_read(input logic [1:0] ch, output logic [CNT_W-1:0] val,
                         output logic vld);
    req = 1'b1;
    idx = ch;
    step();
    val = counter_out;
    vld = counter_valid;
    req = 1'b0;
    $display("read idx=%0d counter_out=%0d valid=%0b state=%b", ch, val, vld, state_out);
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] v;
    logic             vl;
    reset = 1'b0; init = 1'b0; req = 1'b0; idx = 2'd0;
    set_pops(4'b0000); set_empty(4'b1111);
    step(3);
    total++;
    if ({state_out, idle_out, counter_valid, counter_out} !== {2'b00, 1'b0, 1'b0, 5'd0})
      $display("FAIL reset_state: got st=%b idle=%b vld=%b out=%0d, want st=00 idle=0 vld=0 out=0",
               state_out, idle_out, counter_valid, counter_out);
    else passed++;

    reset = 1'b1; init = 1'b1;
    step();
    total++;
    if (state_out !== 2'b01)
      $display("FAIL reset_to_init: got st=%b want 01", state_out);
    else passed++;

    step(4);
    total++;
    if ({state_out, idle_out} !== {2'b01, 1'b0})
      $display("FAIL hold_init: got st=%b idle=%b want st=01 idle=0", state_out, idle_out);
    else passed++;

    init = 1'b0;
    step();
    total++;
    if ({state_out, idle_out} !== {2'b10, 1'b1})
      $display("FAIL init_to_idle: got st=%b idle=%b want st=10 idle=1", state_out, idle_out);
    else passed++;

    for (int c = 0; c < 4; c++) begin
      do_read(c[1:0], v, vl);
      total++;
      if ({vl, v} !== {1'b1, 5'd0})
        $display("FAIL reset_read%0d: got vld=%b out=%0d want vld=1 out=0", c, vl, v);
      else passed++;
    end
  endtask

  task automatic test_single_channel();
    logic [CNT_W-1:0] v;
    logic             vl;
    set_empty(4'b1110);
    set_pops(4'b0001);
    step(6);
    set_pops(4'b0000);
    total++;
    if ({state_out, idle_out} !== {2'b11, 1'b0})
      $display("FAIL active_state: got st=%b idle=%b want st=11 idle=0", state_out, idle_out);
    else passed++;
    do_read(2'd0, v, vl);
    total++;
    if ({vl, v} !== {1'b1, 5'd6})
      $display("FAIL ch4_count: got vld=%b out=%0d want vld=1 out=6", vl, v);
    else passed++;
    step();
    total++;
    if ({counter_valid, counter_out} !== {1'b0, 5'd0})
      $display("FAIL req_low_clears: got vld=%b out=%0d want vld=0 out=0", counter_valid, counter_out);
    else passed++;
  endtask

  task automatic test_empty_pop();
    logic [CNT_W-1:0] v;
    logic             vl;
    set_pops(4'b0010);
    step(3);
    set_pops(4'b0000);
    do_read(2'd1, v, vl);
    total++;
    if ({vl, v} !== {1'b1, 5'd0})
      $display("FAIL ch5_empty_pop: got vld=%b out=%0d want vld=1 out=0", vl, v);
    else passed++;
    set_empty(4'b1100);
    set_pops(4'b0010);
    step(3);
    set_pops(4'b0000);
    do_read(2'd1, v, vl);
    total++;
    if ({vl, v} !== {1'b1, 5'd3})
      $display("FAIL ch5_count: got vld=%b out=%0d want vld=1 out=3", vl, v);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] v;
    logic             vl;
    set_empty(4'b0100);
    set_pops(4'b1000);
    step(33);
    set_pops(4'b0000);
    do_read(2'd3, v, vl);
    total++;
    if ({vl, v} !== {1'b1, 5'd1})
      $display("FAIL ch7_wrap: got vld=%b out=%0d want vld=1 out=1", vl, v);
    else passed++;
  endtask

  task automatic test_same_edge();
    set_empty(4'b0000);
    set_pops(4'b0100);
    step(4);
    req = 1'b1; idx = 2'd2;
    step();
    set_pops(4'b0000);
    $display("read idx=2 counter_out=%0d valid=%0b (pop on same edge)", counter_out, counter_valid);
    total++;
    if ({counter_valid, counter_out} !== {1'b1, 5'd4})
      $display("FAIL same_edge_old: got vld=%b out=%0d want vld=1 out=4", counter_valid, counter_out);
    else passed++;
    step();
    $display("read idx=2 counter_out=%0d valid=%0b", counter_out, counter_valid);
    total++;
    if ({counter_valid, counter_out} !== {1'b1, 5'd5})
      $display("FAIL same_edge_new: got vld=%b out=%0d want vld=1 out=5", counter_valid, counter_out);
    else passed++;
    req = 1'b0;
  endtask

  task automatic test_init_clear();
    logic [CNT_W-1:0] v;
    logic             vl;
    logic [3:0]       m;
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    // Channel c gets c+2 pops over five cycles: counts 2/3/4/5.
    set_empty(4'b0000);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) m[c] = (k < c + 2);
      set_pops(m);
      step();
    end
    set_pops(4'b0000);
    for (int c = 0; c < 4; c++) begin
      do_read(c[1:0], v, vl);
      total++;
      if ({vl, v} !== {1'b1, 5'(c + 2)})
        $display("FAIL pre_init_ch%0d: got vld=%b out=%0d want vld=1 out=%0d", c, vl, v, c + 2);
      else passed++;
    end

    init = 1'b1; req = 1'b1; idx = 2'd3;
    step();
    $display("read idx=3 counter_out=%0d valid=%0b (init high)", counter_out, counter_valid);
    total++;
    if ({state_out, counter_valid, counter_out} !== {2'b01, 1'b0, 5'd0})
      $display("FAIL init_blocks_req: got st=%b vld=%b out=%0d want st=01 vld=0 out=0",
               state_out, counter_valid, counter_out);
    else passed++;
    init = 1'b0; req = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      do_read(c[1:0], v, vl);
      total++;
      if ({vl, v} !== {1'b1, 5'd0})
        $display("FAIL post_init_ch%0d: got vld=%b out=%0d want vld=1 out=0", c, vl, v);
      else passed++;
    end
  endtask

  task automatic test_reset_midburst();
    logic [CNT_W-1:0] v;
    logic             vl;
    set_pops(4'b1111);
    req = 1'b1; idx = 2'd0;
    step(2);
    reset = 1'b0;
    step();
    total++;
    if ({state_out, idle_out, counter_valid, counter_out} !== {2'b00, 1'b0, 1'b0, 5'd0})
      $display("FAIL midburst_reset: got st=%b idle=%b vld=%b out=%0d want st=00 idle=0 vld=0 out=0",
               state_out, idle_out, counter_valid, counter_out);
    else passed++;
    reset = 1'b1; req = 1'b0;
    set_pops(4'b0000);
    step();
    total++;
    if (state_out !== 2'b01)
      $display("FAIL recover_init: got st=%b want 01", state_out);
    else passed++;
    step();
    total++;
    if ({state_out, idle_out} !== {2'b10, 1'b1})
      $display("FAIL recover_idle: got st=%b idle=%b want st=10 idle=1", state_out, idle_out);
    else passed++;
    do_read(2'd0, v, vl);
    total++;
    if ({vl, v} !== {1'b1, 5'd0})
      $display("FAIL recover_read: got vld=%b out=%0d want vld=1 out=0", vl, v);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_empty_pop();
    test_wrap();
    test_same_edge();
    test_init_clear();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
